// File: rtl/sequence_step_counter.sv
// Step sequencer feeding the sequence BRAM reader: divides aclk into steps, walks and wraps the step index, counts passes.
// Optional SEQ_STEP_PAUSE_EN adds a pause input that freezes counting while in RUN.
module sequence_step_counter #(
    parameter int unsigned STEP_WIDTH = 10,
    parameter int unsigned DIV_WIDTH  = 32,
    parameter int unsigned REP_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  enable,
`ifdef SEQ_STEP_PAUSE_EN
    input  logic                  pause,
`endif
    input  logic [DIV_WIDTH-1:0]  samples_per_step,
    input  logic [STEP_WIDTH-1:0] seq_length,
    input  logic [REP_WIDTH-1:0]  repetitions,
    output logic [STEP_WIDTH-1:0] step_index,
    output logic [STEP_WIDTH-1:0] step_index_next,
    output logic                  step_strobe,
    output logic [REP_WIDTH-1:0]  rep_count,
    output logic                  running,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nx;
    logic [DIV_WIDTH-1:0]  sample_cnt, sample_cnt_nx;
    logic [DIV_WIDTH-1:0]  cnt_spp, cnt_spp_nx;
    logic [STEP_WIDTH-1:0] cnt_len, cnt_len_nx;
    logic [REP_WIDTH-1:0]  rep_cfg, rep_cfg_nx;
    logic [STEP_WIDTH-1:0] step_index_nx;
    logic [REP_WIDTH-1:0]  rep_count_nx;
    logic                  step_strobe_nx, running_nx, done_nx;
    logic                  last_sample, last_step, last_pass, hold;

`ifdef SEQ_STEP_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign last_sample = (sample_cnt == cnt_spp - DIV_WIDTH'(1));
    assign last_step   = (step_index == cnt_len - STEP_WIDTH'(1));
    assign last_pass   = (rep_cfg != '0) && (rep_count + REP_WIDTH'(1) == rep_cfg);

    // Lookahead address so the reader can pre-fill its pipeline
    assign step_index_next = (state == IDLE || last_step) ? '0 : step_index + STEP_WIDTH'(1);

    always_ff @(posedge aclk) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            cnt_spp     <= '0;
            cnt_len     <= '0;
            rep_cfg     <= '0;
            step_index  <= '0;
            rep_count   <= '0;
            step_strobe <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            sample_cnt  <= sample_cnt_nx;
            cnt_spp     <= cnt_spp_nx;
            cnt_len     <= cnt_len_nx;
            rep_cfg     <= rep_cfg_nx;
            step_index  <= step_index_nx;
            rep_count   <= rep_count_nx;
            step_strobe <= step_strobe_nx;
            running     <= running_nx;
            done        <= done_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        sample_cnt_nx  = sample_cnt;
        cnt_spp_nx     = cnt_spp;
        cnt_len_nx     = cnt_len;
        rep_cfg_nx     = rep_cfg;
        step_index_nx  = step_index;
        rep_count_nx   = rep_count;
        step_strobe_nx = 1'b0;
        running_nx     = running;
        done_nx        = done;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    // Zero config values are clamped to 1 so a step always has at least one cycle
                    cnt_spp_nx     = (samples_per_step == '0) ? DIV_WIDTH'(1) : samples_per_step;
                    cnt_len_nx     = (seq_length == '0) ? STEP_WIDTH'(1) : seq_length;
                    rep_cfg_nx     = repetitions;
                    state_nx       = RUN;
                    sample_cnt_nx  = '0;
                    step_index_nx  = '0;
                    rep_count_nx   = '0;
                    step_strobe_nx = 1'b1;
                    running_nx     = 1'b1;
                    done_nx        = 1'b0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nx      = IDLE;
                    sample_cnt_nx = '0;
                    step_index_nx = '0;
                    rep_count_nx  = '0;
                    running_nx    = 1'b0;
                    done_nx       = 1'b0;
                end else if (hold) begin
                    step_strobe_nx = 1'b0;
                end else if (!last_sample) begin
                    sample_cnt_nx = sample_cnt + DIV_WIDTH'(1);
                end else begin
                    sample_cnt_nx = '0;
                    if (!last_step) begin
                        step_index_nx  = step_index + STEP_WIDTH'(1);
                        step_strobe_nx = 1'b1;
                    end else if (last_pass) begin
                        // Final pass ends in place of the wrap; index stays on the last step
                        state_nx     = DONE;
                        rep_count_nx = rep_cfg;
                        running_nx   = 1'b0;
                        done_nx      = 1'b1;
                    end else begin
                        step_index_nx  = '0;
                        step_strobe_nx = 1'b1;
                        if (rep_count != '1) begin
                            rep_count_nx = rep_count + REP_WIDTH'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (!enable) begin
                    state_nx      = IDLE;
                    sample_cnt_nx = '0;
                    step_index_nx = '0;
                    rep_count_nx  = '0;
                    running_nx    = 1'b0;
                    done_nx       = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_step_counter.sv
// Directed bench for sequence_step_counter: per-cycle expectations from a closed-form step model queued and compared after each edge.
module tb_sequence_step_counter;

    localparam int unsigned STEP_WIDTH = 10;
    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned REP_WIDTH  = 16;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic                  aclk = 1'b0;
    logic                  reset = 1'b1;
    logic                  enable = 1'b0;
    logic                  pause = 1'b0;
    logic [DIV_WIDTH-1:0]  samples_per_step = '0;
    logic [STEP_WIDTH-1:0] seq_length = '0;
    logic [REP_WIDTH-1:0]  repetitions = '0;
    logic [STEP_WIDTH-1:0] step_index;
    logic [STEP_WIDTH-1:0] step_index_next;
    logic                  step_strobe;
    logic [REP_WIDTH-1:0]  rep_count;
    logic                  running;
    logic                  done;

    sequence_step_counter #(
        .STEP_WIDTH(STEP_WIDTH),
        .DIV_WIDTH (DIV_WIDTH),
        .REP_WIDTH (REP_WIDTH)
    ) dut (
        .aclk            (aclk),
        .reset           (reset),
        .enable          (enable),
`ifdef SEQ_STEP_PAUSE_EN
        .pause           (pause),
`endif
        .samples_per_step(samples_per_step),
        .seq_length      (seq_length),
        .repetitions     (repetitions),
        .step_index      (step_index),
        .step_index_next (step_index_next),
        .step_strobe     (step_strobe),
        .rep_count       (rep_count),
        .running         (running),
        .done            (done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        longint step;
        longint nxt;
        longint strobe;
        longint rep;
        longint run;
        longint dn;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad   = 0;

    int     m_state = M_IDLE;
    longint m_k = 0;
    longint m_spp = 1;
    longint m_len = 1;
    longint m_rep = 0;
    bit     m_paused = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Outputs after the coming edge follow from RUN cycle index k and the latched config
    function automatic exp_t model_outputs();
        exp_t e;
        longint r;
        e = '{0, 0, 0, 0, 0, 0};
        if (m_state == M_RUN) begin
            e.step   = (m_k / m_spp) % m_len;
            e.nxt    = (e.step + 1) % m_len;
            e.strobe = ((m_k % m_spp) == 0 && !m_paused) ? 1 : 0;
            r        = m_k / (m_spp * m_len);
            e.rep    = (r > 65535) ? 65535 : r;
            e.run    = 1;
        end else if (m_state == M_DONE) begin
            e.step = m_len - 1;
            e.nxt  = 0;
            e.rep  = m_rep;
            e.dn   = 1;
        end
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        exp_t g;
        m_paused = 1'b0;
        if (reset) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: if (enable) begin
                    m_spp   = (samples_per_step == '0) ? 1 : longint'(samples_per_step);
                    m_len   = (seq_length == '0) ? 1 : longint'(seq_length);
                    m_rep   = longint'(repetitions);
                    m_k     = 0;
                    m_state = M_RUN;
                end
                M_RUN: if (!enable) begin
                    m_state = M_IDLE;
                end else if (pause) begin
                    m_paused = 1'b1;
                end else begin
                    m_k++;
                    if (m_rep != 0 && m_k >= m_spp * m_len * m_rep) m_state = M_DONE;
                end
                default: if (!enable) m_state = M_IDLE;
            endcase
        end
        e = model_outputs();
        sb.push_back(e);
        @(posedge aclk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            g = sb.pop_front();
            check("step_index", 64'(step_index), 64'(g.step));
            check("step_index_next", 64'(step_index_next), 64'(g.nxt));
            check("step_strobe", 64'(step_strobe), 64'(g.strobe));
            check("rep_count", 64'(rep_count), 64'(g.rep));
            check("running", 64'(running), 64'(g.run));
            check("done", 64'(done), 64'(g.dn));
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg(input int spp, input int len, input int rep);
        samples_per_step = DIV_WIDTH'(spp);
        seq_length       = STEP_WIDTH'(len);
        repetitions      = REP_WIDTH'(rep);
    endtask

    initial begin
        @(posedge aclk);
        #1;
        // Reset state
        reset  = 1'b1;
        enable = 1'b0;
        cycles(5);
        reset = 1'b0;
        cycles(2);

        // Finite run: 4 samples x 3 steps x 2 passes, DONE at RUN cycle 24
        cfg(4, 3, 2);
        enable = 1'b1;
        cycles(6);
        cfg(7, 9, 5);
        cycles(24);
        // Reset while in DONE with enable held, then resume one cycle after release
        reset = 1'b1;
        cycles(2);
        cfg(4, 3, 2);
        reset = 1'b0;
        cycles(6);
        enable = 1'b0;
        cycles(2);

        // Zero config clamps to 1/1/infinite
        cfg(0, 0, 0);
        enable = 1'b1;
        cycles(8);
        enable = 1'b0;
        cycles(1);

        // Lookahead index with wrap 4->0, never done
        cfg(2, 5, 0);
        enable = 1'b1;
        cycles(30);
        enable = 1'b0;
        cycles(1);

        // Abort at RUN cycle 7 and restart
        cfg(3, 4, 0);
        enable = 1'b1;
        cycles(7);
        enable = 1'b0;
        cycles(1);
        enable = 1'b1;
        cycles(5);
        enable = 1'b0;
        cycles(1);

        // Reset mid-step at sample 2
        cfg(4, 3, 0);
        enable = 1'b1;
        cycles(7);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(5);
        enable = 1'b0;
        cycles(1);

`ifdef SEQ_STEP_PAUSE_EN
        // Pause held 3 cycles at sample 1 stretches the step to 7 cycles
        cfg(4, 3, 0);
        enable = 1'b1;
        cycles(2);
        pause = 1'b1;
        cycles(3);
        pause = 1'b0;
        cycles(12);
        pause = 1'b1;
        cycles(2);
        enable = 1'b0;
        cycles(1);
        pause = 1'b0;
        cycles(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
